fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TEXT_BASE, default 32'h00200000, lowest legal instruction word address (start of the instruction half of memory).
REQ-002 Parameter RESET_PC, default 32'h00200005, word address of the first fetch after reset.
REQ-003 Ports, one per line:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- instruction_address  output  32  word address driven to the memory instruction port; equals PC.
- instruction  input  32  combinational instruction word returned by memory for instruction_address; 32'hFFFFFFFF means invalid.
- stall  input  1  pipeline hold; no new fetch is performed while high.
- branch_taken  input  1  one-cycle redirect request.
- branch_target  input  32  word address for the redirect; sampled when branch_taken=1.
- inst_ready  input  1  downstream decode accepts the head entry.
- inst_valid  output  1  head entry of the prefetch buffer is valid.
- inst_out  output  32  instruction word of the head entry.
- pc_out  output  32  word address of the head entry.
- halted  output  1  halt instruction fetched; fetching stopped.
- fault  output  1  invalid fetch or illegal redirect detected; sticky.

Function
REQ-004 The block SHALL hold a 2-entry FIFO of {pc, instruction} pairs; inst_valid=1 iff the FIFO is non-empty; inst_out/pc_out SHALL show the oldest entry.
REQ-005 Pop: when inst_valid=1 and inst_ready=1 on a rising edge, the head entry SHALL be removed.
REQ-006 Fetch condition: a fetch SHALL occur on a rising edge iff halted=0, fault=0, stall=0, branch_taken=0, and (FIFO count<2 or a pop occurs that edge).
REQ-007 On a fetch, {PC, instruction} SHALL be pushed and PC SHALL become PC+1 (32-bit wrap, no saturation).
REQ-008 Simultaneous push and pop with count=2 SHALL leave count=2; with count=1 SHALL leave count=1, the new entry becoming head on the next edge.
REQ-009 Redirect: branch_taken=1 SHALL flush the FIFO (count=0, inst_valid=0 next cycle), discard any same-edge fetch and pop, and load PC with branch_target; redirect SHALL take priority over stall.
REQ-010 A redirect with branch_target < TEXT_BASE SHALL set fault and leave PC unchanged.
REQ-011 Redirect SHALL clear halted; it SHALL NOT clear fault.
REQ-012 A fetched word of 32'hFFFFFFFF SHALL NOT be pushed; it SHALL set fault and PC SHALL hold.
REQ-013 A fetched word with instruction[31:27]=5'b11111 other than 32'hFFFFFFFF is the halt instruction; it SHALL be pushed and halted SHALL be set the same edge; PC SHALL NOT advance.
REQ-014 While halted=1 or fault=1, pops SHALL continue so buffered entries drain.
REQ-015 Fetch latency: an instruction fetched at edge N SHALL be visible on inst_out/pc_out after edge N if the FIFO was empty, otherwise after the entries ahead of it are popped.
REQ-016 instruction_address SHALL always equal PC combinationally; no other output depends combinationally on inputs.

Reset
REQ-017 reset=1 SHALL asynchronously set PC=RESET_PC, FIFO count=0, inst_valid=0, inst_out=0, pc_out=0, halted=0, fault=0.
REQ-018 Reset asserted mid-operation SHALL discard all buffered entries; the first fetch SHALL occur on the first rising edge with reset=0 and REQ-006 met.

Verification
REQ-019 Reset release, stall=0, inst_ready=1, memory preloaded from RESET_PC -> pc_out 32'h00200005, 32'h00200006, 32'h00200007 on consecutive cycles, inst_valid=1 each cycle.
REQ-020 inst_ready=0 for 4 cycles from reset -> exactly 2 entries fetched, instruction_address stops at 32'h00200007; inst_ready=1 -> entries 32'h00200005, 32'h00200006 delivered in order, then fetching resumes.
REQ-021 branch_taken=1, branch_target=32'h00200013 while FIFO holds 2 entries -> next cycle inst_valid=0; following cycle pc_out=32'h00200013.
REQ-022 Memory word 32'hF8000000 at 32'h00200015 -> entry delivered, halted=1, instruction_address stays 32'h00200015; redirect to 32'h00200005 clears halted.
REQ-023 branch_target=32'h00000064 -> fault=1, PC unchanged, no further fetches; fetch from an address returning 32'hFFFFFFFF -> fault=1, nothing pushed.
REQ-024 reset pulsed asynchronously between edges with 2 entries buffered -> inst_valid=0, PC=RESET_PC immediately, halted=0, fault=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register feeding a 2-entry {pc, instruction} prefetch buffer.
// Fetched word shows on the head one edge after fetch when empty; fetching holds on stall, full buffer, halt or fault.
module fetch_unit #(
    parameter logic [31:0] TEXT_BASE = 32'h00200000,
    parameter logic [31:0] RESET_PC  = 32'h00200005
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instruction_address,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic        fault
);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
    logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;

    logic pop, fetch, push, is_bad, is_halt;

    always_comb begin
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        pc0_d    = pc0_q;
        ins0_d   = ins0_q;
        pc1_d    = pc1_q;
        ins1_d   = ins1_q;
        halted_d = halted_q;
        fault_d  = fault_q;

        pop     = (cnt_q != 2'd0) && inst_ready;
        fetch   = !halted_q && !fault_q && !stall && !branch_taken
                  && ((cnt_q != 2'd2) || pop);
        is_bad  = (instruction == 32'hFFFF_FFFF);
        is_halt = (instruction[31:27] == 5'b11111) && !is_bad;
        push    = fetch && !is_bad;

        if (branch_taken) begin
            // Redirect wins over everything: buffer flushed, same-edge pop and fetch dropped.
            cnt_d    = 2'd0;
            halted_d = 1'b0;
            if (branch_target < TEXT_BASE) begin
                fault_d = 1'b1;
            end else begin
                pc_d = branch_target;
            end
        end else begin
            if (fetch) begin
                if (is_bad) begin
                    fault_d = 1'b1;
                end else if (is_halt) begin
                    halted_d = 1'b1;
                end else begin
                    pc_d = pc_q + 32'd1;
                end
            end

            case ({push, pop})
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        pc0_d  = pc1_q;
                        ins0_d = ins1_q;
                        pc1_d  = pc_q;
                        ins1_d = instruction;
                    end else begin
                        pc0_d  = pc_q;
                        ins0_d = instruction;
                    end
                end
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        pc0_d  = pc_q;
                        ins0_d = instruction;
                    end else begin
                        pc1_d  = pc_q;
                        ins1_d = instruction;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    pc0_d  = pc1_q;
                    ins0_d = ins1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            cnt_q    <= 2'd0;
            pc0_q    <= 32'd0;
            ins0_q   <= 32'd0;
            pc1_q    <= 32'd0;
            ins1_q   <= 32'd0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            pc0_q    <= pc0_d;
            ins0_q   <= ins0_d;
            pc1_q    <= pc1_d;
            ins1_q   <= ins1_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign instruction_address = pc_q;
    assign inst_valid          = (cnt_q != 2'd0);
    assign inst_out            = ins0_q;
    assign pc_out              = pc0_q;
    assign halted              = halted_q;
    assign fault               = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: combinational memory model, scoreboard of expected deliveries.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction_address;
    logic [31:0] instruction;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        inst_ready = 1'b1;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        halted;
    logic        fault;

    logic [31:0] halt_addr = 32'd0;
    logic [31:0] bad_addr  = 32'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    fetch_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .instruction_address (instruction_address),
        .instruction         (instruction),
        .stall               (stall),
        .branch_taken        (branch_taken),
        .branch_target       (branch_target),
        .inst_ready          (inst_ready),
        .inst_valid          (inst_valid),
        .inst_out            (inst_out),
        .pc_out              (pc_out),
        .halted              (halted),
        .fault               (fault)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (instruction_address == bad_addr)
            instruction = 32'hFFFF_FFFF;
        else if (instruction_address == halt_addr)
            instruction = 32'hF800_0000;
        else
            instruction = 32'h1000_0000 ^ instruction_address;
    end

    function automatic logic [31:0] plain_word(logic [31:0] a);
        return 32'h1000_0000 ^ a;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_run(logic [31:0] first, int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{pc: first + i, ins: plain_word(first + i)});
    endtask

    // An accepted head entry is consumed at the next edge unless a redirect discards it.
    always @(negedge clk) begin
        if (!reset && inst_valid && inst_ready && !branch_taken) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                ent_t e;
                e = exp_q.pop_front();
                chk("sb_pc", pc_out, e.pc);
                chk("sb_ins", inst_out, e.ins);
            end
        end
    end

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_addr", instruction_address, 32'h00200005);

        // Streaming from reset with decode always ready.
        @(posedge clk); #1;
        reset = 1'b0;
        expect_run(32'h00200005, 5);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stream_valid", inst_valid, 1);
            if (i < 3) chk("stream_pc", pc_out, 32'h00200005 + i);
        end
        chk("stream_sb_empty", exp_q.size(), 0);

        // Fill the buffer, then reset asynchronously between edges.
        inst_ready = 1'b0;
        step();
        step();
        chk("full_addr", instruction_address, 32'h0020000C);
        chk("full_pc", pc_out, 32'h0020000A);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", inst_valid, 0);
        chk("arst_addr", instruction_address, 32'h00200005);
        chk("arst_pc", pc_out, 0);
        #2 reset = 1'b0;

        // Backpressure from reset: two entries buffered, then drained in order.
        for (int i = 0; i < 4; i++) step();
        chk("bp_addr", instruction_address, 32'h00200007);
        chk("bp_valid", inst_valid, 1);
        chk("bp_pc", pc_out, 32'h00200005);
        expect_run(32'h00200005, 4);
        inst_ready = 1'b1;
        step();
        chk("bp_pc2", pc_out, 32'h00200006);
        step();
        step();
        step();
        chk("bp_sb_empty", exp_q.size(), 0);

        // Redirect with a full buffer, asserted together with stall.
        chk("br_pre_valid", inst_valid, 1);
        halt_addr     = 32'h00200015;
        branch_taken  = 1'b1;
        stall         = 1'b1;
        branch_target = 32'h00200013;
        step();
        branch_taken = 1'b0;
        stall        = 1'b0;
        chk("br_flush_valid", inst_valid, 0);
        chk("br_addr", instruction_address, 32'h00200013);
        expect_run(32'h00200013, 2);
        exp_q.push_back('{pc: 32'h00200015, ins: 32'hF800_0000});
        step();
        chk("br_pc", pc_out, 32'h00200013);
        step();
        step();
        chk("halt_set", halted, 1);
        chk("halt_addr", instruction_address, 32'h00200015);
        step();
        chk("halt_drained", inst_valid, 0);
        step();
        chk("halt_addr_hold", instruction_address, 32'h00200015);
        chk("halt_sb_empty", exp_q.size(), 0);

        // Redirect clears halt.
        branch_taken  = 1'b1;
        branch_target = 32'h00200005;
        step();
        chk("unhalt", halted, 0);
        chk("unhalt_addr", instruction_address, 32'h00200005);

        // Redirect below the text region faults and leaves PC alone.
        branch_target = 32'h00000064;
        step();
        branch_taken = 1'b0;
        chk("ill_fault", fault, 1);
        chk("ill_addr", instruction_address, 32'h00200005);
        chk("ill_valid", inst_valid, 0);
        step();
        step();
        chk("ill_nofetch_addr", instruction_address, 32'h00200005);
        chk("ill_nofetch_valid", inst_valid, 0);

        // A legal redirect moves PC but keeps the sticky fault.
        branch_taken  = 1'b1;
        branch_target = 32'h00200020;
        step();
        branch_taken = 1'b0;
        chk("sticky_fault", fault, 1);
        chk("sticky_addr", instruction_address, 32'h00200020);
        step();
        chk("sticky_valid", inst_valid, 0);
        chk("sticky_addr2", instruction_address, 32'h00200020);

        // Asynchronous reset clears fault; stall then holds fetching.
        #2 reset = 1'b1;
        #1;
        chk("arst2_fault", fault, 0);
        chk("arst2_halted", halted, 0);
        chk("arst2_addr", instruction_address, 32'h00200005);
        bad_addr = 32'h00200007;
        stall    = 1'b1;
        #2 reset = 1'b0;
        step();
        chk("stall_valid", inst_valid, 0);
        step();
        chk("stall_addr", instruction_address, 32'h00200005);
        stall = 1'b0;
        expect_run(32'h00200005, 2);
        step();
        chk("post_stall_pc", pc_out, 32'h00200005);
        step();
        step();
        chk("badword_fault", fault, 1);
        chk("badword_addr", instruction_address, 32'h00200007);
        chk("badword_valid", inst_valid, 0);
        step();
        chk("badword_hold", instruction_address, 32'h00200007);
        chk("badword_nopush", inst_valid, 0);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
